// File: rtl/btn_led_pkg.sv
// Shared definitions for the button / LED mode controller: the LED mode
// encoding and the press-to-press mode sequence.
package btn_led_pkg;

  // Two-bit mode encoding, also driven directly onto the mode output.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  // Mode that follows the given one on a press: OFF, ON, SLOW, FAST, OFF.
  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_OFF:  nxt = MODE_ON;
      MODE_ON:   nxt = MODE_SLOW;
      MODE_SLOW: nxt = MODE_FAST;
      MODE_FAST: nxt = MODE_OFF;
      default:   nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus a counter debouncer for an active-low,
// pulled-up push button. A level change is accepted only after the
// synchronized input has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive clocks; any bounce back restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,       // raw level, 0 = pressed, asynchronous to clk
  output logic db_level_o,    // accepted (debounced) level, 1 = released
  output logic fall_pulse_o,  // registered one-clock strobe after a press is accepted
  output logic fall_accept_o  // combinational: a press is accepted at the coming edge
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // Synchronizer, accepted level, stability counter and press strobe.
  // NOTE: the synchronizer flops reset to 1 (released) so that leaving reset
  // never looks like a press edge; every sequential assignment is
  // non-blocking so all flops sample the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      db_q   <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= btn_n_i;
      s2_q   <= s1_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  // Debounce decision: clear on agreement, count on disagreement, accept at
  // the last count.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign db_level_o    = db_q;
  assign fall_pulse_o  = fall_q;
  assign fall_accept_o = fall_d;

endmodule

// File: rtl/btn_led_mode_ctrl.sv
// Single-button / single-LED controller. Each debounced press steps the LED
// through OFF, ON, BLINK_SLOW and BLINK_FAST. The blink generator restarts
// in the lit phase on every mode change, and the LED drive comes straight
// from a flop so it cannot glitch.
module btn_led_mode_ctrl
  import btn_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SLOW_HALF       = 6250000,
  parameter int FAST_HALF       = 1250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_n_raw,
  output logic       led,
  output logic [1:0] mode,
  output logic       press_pulse
);

  localparam int BLINK_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int BW        = $clog2(BLINK_MAX);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);

  logic          press_now;
  logic          unused_db_level;  // accepted level is not needed by this block

  mode_e         mode_q, mode_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          led_q, led_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (reset_n),
    .btn_n_i      (btn_n_raw),
    .db_level_o   (unused_db_level),
    .fall_pulse_o (press_pulse),
    .fall_accept_o(press_now)
  );

  // Mode, blink counter, blink phase and LED drive registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  // Next mode on the press edge, blink half-period timing, and the LED value
  // decoded from the next-state terms so the led flop matches mode and phase.
  always_comb begin
    mode_d      = mode_q;
    blink_cnt_d = '0;
    phase_d     = phase_q;
    led_d       = 1'b0;

    if (press_now) begin
      mode_d = next_mode(mode_q);
    end

    if (mode_d != mode_q) begin
      // Any mode change restarts the blink in the lit half, cutting short
      // whatever half-period was in progress.
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else begin
      case (mode_q)
        MODE_SLOW: begin
          if (blink_cnt_q == SLOW_LAST) begin
            phase_d = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
        MODE_FAST: begin
          if (blink_cnt_q == FAST_LAST) begin
            phase_d = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
        default: blink_cnt_d = '0;
      endcase
    end

    case (mode_d)
      MODE_OFF: led_d = 1'b0;
      MODE_ON:  led_d = 1'b1;
      default:  led_d = phase_d;
    endcase
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: doc/btn_led_mode_ctrl.md
Name: btn_led_mode_ctrl

Overview:
- Controller for the single-button / single-LED resource on the breakout board.
- Takes the raw pulled-up button input (active-low, supplied by the top-level SB_IO) and synchronizes and debounces it.
- Each clean press steps the LED through a four-mode sequence: OFF, ON, BLINK_SLOW, BLINK_FAST, then back to OFF.
- Sits between the top-level IO cells and the led pin; it replaces the direct button-to-LED wire.

Parameters:
- DEBOUNCE_CYCLES, 250000: clocks the synchronized input must differ stably from the accepted state before a change is accepted (10 ms at 25 MHz). Must be ≥2.
- SLOW_HALF, 6250000: clocks per half-period in BLINK_SLOW (2 Hz blink at 25 MHz). Must be ≥2.
- FAST_HALF, 1250000: clocks per half-period in BLINK_FAST (10 Hz blink at 25 MHz). Must be ≥2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- btn_n_raw  input  1  raw button level from the IO cell; 0 = pressed, asynchronous to clk.
- led  output  1  LED drive; 1 = lit.
- mode  output  2  current mode: 0 = OFF, 1 = ON, 2 = BLINK_SLOW, 3 = BLINK_FAST.
- press_pulse  output  1  one-clock strobe per accepted press.

Behaviour:
- Reset (async assert, sync release by the board reset network):
  - sync flops = 1, accepted state db = 1 (released), debounce counter = 0.
  - mode = OFF, blink counter = 0, phase = 1.
  - Outputs: led = 0, mode = 0, press_pulse = 0.
- Synchronizer: two flops, s1 then s2. Only s2 is used downstream.
- Debounce:
  - s2 == db: counter cleared to 0.
  - s2 != db and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != db and counter == DEBOUNCE_CYCLES-1: db <= s2 and counter <= 0.
  - Any bounce back to equality before acceptance clears the counter, so no partial credit accumulates.
  - Counter width = $clog2(DEBOUNCE_CYCLES).
- Press event: press_pulse = 1 on exactly the edge where db is accepted 1->0. It is high for one clock only.
  - Release (0->1 acceptance) produces no event.
- Latency: with btn_n_raw stable low from before edge 1, press_pulse and the mode update appear at edge DEBOUNCE_CYCLES+2.
- Mode FSM:
  - Sequence: OFF->ON->BLINK_SLOW->BLINK_FAST->OFF.
  - Advances only on the same edge press_pulse is asserted; mode is registered.
  - A held button produces exactly one advance.
- Blink:
  - On every mode change: blink counter <= 0, phase <= 1.
  - In a blink mode, the counter increments each clock. At HALF-1 (HALF = SLOW_HALF or FAST_HALF) it wraps to 0 and phase toggles.
  - In OFF/ON the counter is held at 0.
  - Counter width = $clog2(max(SLOW_HALF, FAST_HALF)).
- LED: led = 0 in OFF, 1 in ON, phase in blink modes. All terms are registered, so led is glitch-free.
- On entering a blink mode the LED is lit for exactly HALF clocks first.
- reset_n asserted mid-debounce or mid-blink: all state returns to reset values immediately.
  - After release, a button already held low is accepted as a new press after DEBOUNCE_CYCLES+2 edges.
- A press arriving during a blink half-period advances the mode immediately; the current half-period is not completed.

Decomposition:
- Package btn_led_pkg holds:
  - mode encoding constants MODE_OFF, MODE_ON, MODE_SLOW, MODE_FAST (2-bit);
  - a next-mode function.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES):
  - Contains the synchronizer and debounce counter.
  - Outputs db_level and fall_pulse.
  - Reusable for future board buttons.
- The mode FSM and blink generator stay in btn_led_mode_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, SLOW_HALF=8, FAST_HALF=2):
- Reset check: assert reset_n=0 with btn_n_raw=0, then release -> led=0, mode=0, press_pulse=0 during reset; the held button yields press_pulse at edge 6 after release and mode=1.
- Clean press: btn_n_raw 1->0 held 20 clocks -> press_pulse high for one clock at edge 6, mode=1, led=1, no further pulses while held; release produces no pulse.
- Bounce rejection: btn_n_raw low 3 clocks, high 1, low 3, high -> no press_pulse, mode stays 0; then low 10 clocks -> exactly one press_pulse.
- Full cycle: four clean presses -> mode sequence 1,2,3,0; led=0 after the fourth.
- Blink timing:
  - In BLINK_SLOW, led=1 for 8 clocks, then 0 for 8, repeating.
  - After the next press (BLINK_FAST), led=1 for 2, then 0 for 2.
  - Phase restarts at 1 on each mode entry.
- Async reset mid-blink: assert reset_n=0 halfway through a BLINK_FAST half-period -> led=0 and mode=0 immediately, without waiting for a clock edge.
